// File: rtl/serial_reduce_and.sv
// serial_reduce_and -- bit-serial AND reduction of a COUNT_OF_BITS-wide operand.
//
// The operand is captured into a shadow register when accepted, then examined
// one bit per clock, LSB first, through a single NAND-built AND gate
// (sheffer_and). The result is presented on a valid/ready output handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   bitvector  in   [COUNT_OF_BITS-1:0] operand, sampled only on acceptance
//   in_valid   in   operand valid
//   in_ready   out  block can accept an operand (IDLE only, low during reset)
//   reduce     out  registered AND of the examined bits
//   processed  out  registered count of bits examined
//   out_valid  out  reduce/processed valid (DONE only)
//   out_ready  in   consumer takes the result
//
// Build option:
//   SERIAL_REDUCE_EARLY_EXIT_EN  when defined, the scan stops at the first
//                                zero bit (reduce=0, processed=index+1).

// Two-input AND composed of NAND (Sheffer stroke) operations.
module sheffer_and (
   input  logic a,
   input  logic b,
   output logic y
);
   logic nand_ab;

   assign nand_ab = ~(a & b);
   assign y       = ~(nand_ab & nand_ab);
endmodule

module serial_reduce_and #(
   parameter int COUNT_OF_BITS = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [COUNT_OF_BITS-1:0]           bitvector,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic                               reduce,
   output logic [$clog2(COUNT_OF_BITS+1)-1:0] processed,
   output logic                               out_valid,
   input  logic                               out_ready
);
   localparam int PW = $clog2(COUNT_OF_BITS + 1);
   // A one-bit operand still needs a one-bit index register.
   localparam int IW = (COUNT_OF_BITS > 1) ? $clog2(COUNT_OF_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_reg;
   state_t                   state_next;
   logic [COUNT_OF_BITS-1:0] shadow_reg;
   logic                     acc_reg;
   logic [IW-1:0]            idx_reg;
   logic                     reduce_reg;
   logic [PW-1:0]            processed_reg;
   logic                     out_valid_reg;

   logic cur_bit;
   logic acc_and;
   logic last_bit;
   logic stop_run;
   logic accept;
   logic consume;

   assign cur_bit  = shadow_reg[idx_reg];
   assign last_bit = (idx_reg == IW'(COUNT_OF_BITS - 1));

   sheffer_and u_and (
      .a (acc_reg),
      .b (cur_bit),
      .y (acc_and)
   );

`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
   // A zero bit already decides the result; stop scanning there.
   assign stop_run = last_bit | ~cur_bit;
`else
   assign stop_run = last_bit;
`endif

   assign accept  = (state_reg == IDLE) & in_valid;
   // The result is only offered once out_valid is up, so out_ready in the
   // first DONE cycle is ignored.
   assign consume = (state_reg == DONE) & out_valid_reg & out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)   state_next = RUN;
         RUN:     if (stop_run) state_next = DONE;
         DONE:    if (consume)  state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // Datapath: shadow capture, serial accumulate, result and valid registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_reg    <= '0;
         acc_reg       <= 1'b1;
         idx_reg       <= '0;
         reduce_reg    <= 1'b0;
         processed_reg <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  shadow_reg <= bitvector;
                  acc_reg    <= 1'b1;
                  idx_reg    <= '0;
               end
            end
            RUN: begin
               acc_reg <= acc_and;
               idx_reg <= idx_reg + IW'(1);
               if (stop_run) begin
                  reduce_reg    <= acc_and;
                  // idx never exceeds COUNT_OF_BITS-1, so idx+1 fits in PW bits
                  processed_reg <= PW'(idx_reg) + PW'(1);
               end
            end
            DONE: begin
               // out_valid follows the DONE entry by one edge, giving the
               // COUNT_OF_BITS+1 edge acceptance-to-valid latency.
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE) & ~rst;
   assign reduce    = reduce_reg;
   assign processed = processed_reg;
   assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_serial_reduce_and.sv
// tb_serial_reduce_and -- self-checking bench for serial_reduce_and with
// COUNT_OF_BITS=4: a directed vector table, hand-written multi-cycle
// sequences (backpressure, operand isolation, mid-run reset) and random
// back-to-back traffic checked against a behavioural model.
module tb_serial_reduce_and;
   localparam int N = 4;
`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [N-1:0] bitvector;
   logic         in_valid;
   logic         in_ready;
   logic         reduce;
   logic [2:0]   processed;
   logic         out_valid;
   logic         out_ready;

   int checks;
   int failures;

   serial_reduce_and #(.COUNT_OF_BITS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .bitvector (bitvector),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .reduce    (reduce),
      .processed (processed),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vec;
      logic       exp_reduce;
      logic [2:0] exp_proc;
      int         exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: result is the AND of all four bits; with early exit the scan
   // ends at the first zero bit, otherwise all four bits are always examined.
   function automatic void model(input logic [3:0] v, output logic r,
                                 output logic [2:0] p, output int lat);
      int first_zero;
      first_zero = -1;
      for (int i = 0; i < N; i++) begin
         if (v[i] == 1'b0 && first_zero < 0) first_zero = i;
      end
      r = (v == 4'hF);
      if (EE && first_zero >= 0) begin
         p   = 3'(first_zero + 1);
         lat = first_zero + 2;
      end else begin
         p   = 3'(N);
         lat = N + 1;
      end
   endfunction

   // Called at a negedge. Offers v, waits (bounded) for acceptance, then counts
   // edges until out_valid. keep_valid leaves in_valid high and scrambles
   // bitvector during the run. Returns at the negedge where out_valid was seen.
   task automatic do_op(input logic [3:0] v, input bit keep_valid,
                        output logic r, output logic [2:0] p, output int lat,
                        output int wait_cycles, output bit saw_ready);
      wait_cycles = 0;
      saw_ready   = 1'b0;
      lat         = 0;
      bitvector   = v;
      in_valid    = 1'b1;
      while (!in_ready && wait_cycles < 50) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (!in_ready) begin
         failures++;
         checks++;
         $display("FAIL accept_timeout: in_ready never rose for vec=%b", v);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = keep_valid;
      while (!out_valid && lat < 50) begin
         if (in_ready) saw_ready = 1'b1;
         bitvector = 4'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r = reduce;
      p = processed;
      $display("op vec=%b reduce=%0d processed=%0d latency=%0d", v, r, p, lat);
   endtask

   vec_t table_v[6];

   initial begin
      logic       r;
      logic [2:0] p;
      logic       er;
      logic [2:0] ep;
      int         lat;
      int         elat;
      int         wc;
      bit         sr;
      bit         stable;
      bit         pulse;
      logic       r0;
      logic [2:0] p0;

      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      bitvector = '0;

      table_v[0] = '{4'b1111, 1'b1, 3'd4, 5};
      table_v[1] = '{4'b1101, 1'b0, EE ? 3'd2 : 3'd4, EE ? 3 : 5};
      table_v[2] = '{4'b0000, 1'b0, EE ? 3'd1 : 3'd4, EE ? 2 : 5};
      table_v[3] = '{4'b0111, 1'b0, 3'd4, 5};
      table_v[4] = '{4'b1110, 1'b0, EE ? 3'd1 : 3'd4, EE ? 2 : 5};
      table_v[5] = '{4'b1011, 1'b0, EE ? 3'd3 : 3'd4, EE ? 4 : 5};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_reduce", 32'(reduce), 32'd0);
      check("rst_processed", 32'(processed), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Directed table, out_ready held high
      foreach (table_v[i]) begin
         do_op(table_v[i].vec, 1'b0, r, p, lat, wc, sr);
         check("tbl_reduce", 32'(r), 32'(table_v[i].exp_reduce));
         check("tbl_processed", 32'(p), 32'(table_v[i].exp_proc));
         check("tbl_latency", 32'(lat), 32'(table_v[i].exp_lat));
         check("tbl_no_ready_in_run", 32'(sr), 32'd0);
         @(posedge clk);
         @(negedge clk);
         check("tbl_consumed", 32'(out_valid), 32'd0);
         check("tbl_ready_after", 32'(in_ready), 32'd1);
      end

      // Backpressure: hold the result for 10 cycles
      out_ready = 1'b0;
      do_op(4'b1111, 1'b0, r, p, lat, wc, sr);
      check("bp_latency", 32'(lat), 32'd5);
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || reduce !== 1'b1 || processed !== 3'd4 || in_ready !== 1'b0)
            stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_one_transfer", 32'(out_valid), 32'd0);
      check("bp_ready_next", 32'(in_ready), 32'd1);

      // Operand isolation: in_valid stays high, bitvector scrambled during run
      do_op(4'b1111, 1'b1, r, p, lat, wc, sr);
      bitvector = 4'b0000;
      check("iso_reduce", 32'(r), 32'd1);
      check("iso_processed", 32'(p), 32'd4);
      check("iso_no_second_accept", 32'(sr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("iso_consumed", 32'(out_valid), 32'd0);
      @(negedge clk);

      // Mid-run reset, two edges into RUN
      bitvector = 4'b1111;
      in_valid  = 1'b1;
      @(posedge clk);           // accepting edge
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst_ready_after", 32'(in_ready), 32'd1);
      pulse = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) pulse = 1'b1;
      end
      check("mrst_no_pulse", 32'(pulse), 32'd0);
      do_op(4'b0111, 1'b0, r, p, lat, wc, sr);
      check("mrst_next_reduce", 32'(r), 32'd0);
      @(posedge clk);
      @(negedge clk);

      // Random back-to-back traffic
      for (int k = 0; k < 40; k++) begin
         logic [3:0] v;
         v = 4'($urandom);
         model(v, er, ep, elat);
         do_op(v, 1'b1, r, p, lat, wc, sr);
         check("rnd_reduce", 32'(r), 32'(er));
         check("rnd_processed", 32'(p), 32'(ep));
         check("rnd_latency", 32'(lat), 32'(elat));
         if (k > 0) check("rnd_accept_delay", 32'(wc), 32'd0);
         r0 = reduce;
         p0 = processed;
         @(posedge clk);
         @(negedge clk);
         check("rnd_consumed", 32'(out_valid), 32'd0);
         check("rnd_ready_after", 32'(in_ready), 32'd1);
         check("rnd_hold_reduce", 32'(reduce), 32'(r0));
         check("rnd_hold_processed", 32'(processed), 32'(p0));
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_reduce_and.md
SERIAL_REDUCE_AND -- requirements
Module: serial_reduce_and

Interface
REQ-001 SHALL have parameter COUNT_OF_BITS, default 4, meaning the input vector width; legal range is COUNT_OF_BITS >= 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port bitvector, input, COUNT_OF_BITS bits: the operand, sampled on acceptance.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-007 SHALL have port reduce, output, 1 bit: the AND of all operand bits.
REQ-008 SHALL have port processed, output, $clog2(COUNT_OF_BITS+1) bits: the number of bits examined.
REQ-009 SHALL have port out_valid, output, 1 bit: reduce and processed are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, RUN, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 IDLE: when in_valid && in_ready on a clock edge, SHALL latch bitvector into an internal shadow register, set acc=1 and idx=0, and go to RUN.
REQ-014 RUN: on each edge, SHALL update acc <= acc AND shadow[idx], computed by one sheffer_and instance, and increment idx; examination is LSB-first.
REQ-015 RUN: when the bit just examined has index COUNT_OF_BITS-1, SHALL go to DONE with processed=COUNT_OF_BITS.
REQ-016 Latency without early exit: out_valid SHALL rise exactly COUNT_OF_BITS+1 edges after the accepting edge.
REQ-017 DONE: reduce, processed and out_valid SHALL hold stable until out_ready=1 on an edge; the block then returns to IDLE.
REQ-018 A new operand SHALL NOT be accepted on the same edge a result is consumed; in_ready rises in the cycle after consumption.
REQ-019 Changes on bitvector or in_valid outside the accepting edge SHALL NOT affect the result in progress.
REQ-020 For COUNT_OF_BITS=1, RUN SHALL last exactly one edge.
REQ-021 reduce and processed SHALL be registered outputs, with no combinational path from any input.
REQ-022 In IDLE and RUN, reduce and processed SHALL hold their last result value and SHALL be ignored by the consumer.

Reset
REQ-023 rst=1 SHALL asynchronously force the state to IDLE, acc=1, idx=0, reduce=0, processed=0 and out_valid=0, and drive in_ready=0 while rst is high.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation and discard the result, with no output pulse.
REQ-025 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro SERIAL_REDUCE_EARLY_EXIT_EN: when defined, RUN SHALL go to DONE on the first examined bit equal to 0, with reduce=0 and processed equal to that bit's index+1.
REQ-027 Without SERIAL_REDUCE_EARLY_EXIT_EN, all COUNT_OF_BITS bits SHALL always be examined, and processed SHALL always equal COUNT_OF_BITS.

Verification
REQ-028 All bench scenarios below SHALL use COUNT_OF_BITS=4.
REQ-029 Scenario all ones: bitvector=4'b1111, out_ready=1 -> out_valid rises 5 edges after acceptance, reduce=1, processed=4.
REQ-030 Scenario early exit: bitvector=4'b1101 -> with the macro, reduce=0 and processed=2 after 3 edges; without it, reduce=0 and processed=4 after 5 edges.
REQ-031 Scenario backpressure: bitvector=4'b1111, out_ready=0 for 10 cycles -> out_valid, reduce and processed stay stable and in_ready=0; raise out_ready -> one transfer, then in_ready=1 on the next cycle.
REQ-032 Scenario operand isolation: accept 4'b1111, then drive bitvector=4'b0000 with in_valid=1 during RUN -> result reduce=1, and no second acceptance occurs before consumption.
REQ-033 Scenario mid-run reset: assert rst 2 edges into RUN -> out_valid=0 and in_ready=0 immediately; after release, in_ready=1, and the next operand 4'b0111 yields reduce=0.
REQ-034 Scenario back-to-back: random vectors with in_valid and out_ready held at 1 -> each result equals &bitvector, and a new operand is accepted one cycle after each consumption.
